// File: rtl/uart_pkg.sv
// Shared UART definitions: default word width, default bit timing and the word type.
package uart_pkg;

    localparam int DATA_BITS      = 8;
    localparam int CLOCKS_PER_BIT = 868;

    typedef logic [DATA_BITS-1:0] uart_word_t;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo_if.sv
// Producer-to-FIFO and FIFO-to-transmitter handshake bundle.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS
);

    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_send;
    logic                 tx_busy;

    // master is the environment (producer plus transmitter), slave is the FIFO
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  tx_data,
        input  tx_send,
        output tx_busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output tx_data,
        output tx_send,
        input  tx_busy
    );

endinterface : uart_tx_fifo_if

// File: rtl/uart_tx_fifo_chk.sv
// Protocol and occupancy checker for uart_tx_fifo, attached alongside the FIFO.
module uart_tx_fifo_chk #(
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    input logic          in_valid,
    input logic          in_ready,
    input logic          tx_send,
    input logic          tx_busy,
    input logic [CW-1:0] count,
    input logic          empty,
    input logic          full
);

    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] expect_q;

    assign push_s = in_valid && in_ready;
    assign pop_s  = tx_send && !tx_busy;

    // Independent occupancy tally: pushes minus pops since the last flush or reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expect_q <= {CW{1'b0}};
        end else if (flush) begin
            expect_q <= {CW{1'b0}};
        end else begin
            expect_q <= expect_q + CW'(push_s) - CW'(pop_s);
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push_s && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop_s && empty));
    a_count_track:  assert property (@(posedge clk) disable iff (rst) count == expect_q);
    a_count_range:  assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
    a_empty_flag:   assert property (@(posedge clk) disable iff (rst) empty == (count == {CW{1'b0}}));

endmodule : uart_tx_fifo_chk

// File: rtl/uart_tx_fifo_mem.sv
// FIFO storage: register array with a synchronous write port and an asynchronous read port.
module fifo_mem #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    // Storage write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : fifo_mem

// File: rtl/uart_tx_fifo.sv
// Transmit-side word FIFO feeding the UART transmitter's send/data/busy load interface.
import uart_pkg::*;

module uart_tx_fifo #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS,
    parameter int DEPTH     = 16,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_fifo_if.slave        bus,
    input  logic                 flush,
    output logic [CW-1:0]        count,
    output logic                 empty,
    output logic                 full
);

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q,  count_d;
    logic                 empty_q,  empty_d;
    logic                 full_q,   full_d;
    logic                 push_s;
    logic                 pop_s;
    logic                 wr_en_s;
    logic [DATA_BITS-1:0] rd_data_s;

    // Handshake qualifiers depend only on registered flags, so in_ready never sees a same-cycle pop
    assign push_s  = bus.in_valid && !full_q;
    assign pop_s   = !empty_q && !bus.tx_busy;
    assign wr_en_s = push_s && !flush;

    // Next-state for pointers, occupancy and flags; flush wins over push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        empty_d = (count_d == {CW{1'b0}});
        full_d  = (count_d == CW'(DEPTH));
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    fifo_mem #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wr_ptr_q),
        .wdata (bus.in_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data_s)
    );

    assign bus.in_ready = !full_q;
    assign bus.tx_send  = !empty_q;
    assign bus.tx_data  = rd_data_s;
    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH = 16, 8-bit words).
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = 5;
    localparam int CPB   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo_if #(.DATA_BITS(8)) bus ();

    uart_tx_fifo #(.DATA_BITS(8), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .flush (flush),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    uart_tx_fifo_chk #(.DEPTH(DEPTH)) chk (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (bus.in_valid),
        .in_ready (bus.in_ready),
        .tx_send  (bus.tx_send),
        .tx_busy  (bus.tx_busy),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] sb[$];
        int mcnt;
        int loads;
        int busy_cnt;
        int cyc;
        int sent;
        int popped;
        logic do_push;
        logic do_pop;

        rst          = 1'b1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.tx_busy  = 1'b0;
        step();
        step();
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full",  32'(full),  32'd0);
        check_eq("rst_send",  32'(bus.tx_send), 32'd0);
        rst = 1'b0;
        step();
        check_eq("rst_ready", 32'(bus.in_ready), 32'd1);

        // Single word, popped in the first cycle it is visible
        push_word(8'hA5);
        check_eq("single_send",  32'(bus.tx_send), 32'd1);
        check_eq("single_data",  32'(bus.tx_data), 32'hA5);
        check_eq("single_count", 32'(count), 32'd1);
        step();
        check_eq("single_count0", 32'(count), 32'd0);
        check_eq("single_empty",  32'(empty), 32'd1);

        // Burst to full with the transmitter busy
        bus.tx_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push_word(8'(i));
        end
        check_eq("burst_full",  32'(full), 32'd1);
        check_eq("burst_ready", 32'(bus.in_ready), 32'd0);
        check_eq("burst_count", 32'(count), 32'd16);
        push_word(8'hEE);
        check_eq("burst_reject", 32'(count), 32'd16);
        check_eq("burst_head",   32'(bus.tx_data), 32'h00);

        // Drain against a model transmitter busy for 10 bit-times per load
        bus.tx_busy = 1'b0;
        mcnt     = DEPTH;
        loads    = 0;
        busy_cnt = 0;
        cyc      = 0;
        while (loads < DEPTH && cyc < 2000) begin
            cyc++;
            if (bus.tx_send && !bus.tx_busy) begin
                check_eq("drain_order", 32'(bus.tx_data), 32'(loads));
                step();
                loads++;
                mcnt--;
                bus.tx_busy = 1'b1;
                busy_cnt    = 10 * CPB;
            end else begin
                step();
                if (busy_cnt > 0) busy_cnt--;
                if (busy_cnt == 0) bus.tx_busy = 1'b0;
            end
            check_eq("drain_count", 32'(count), 32'(mcnt));
        end
        check_eq("drain_loads", 32'(loads), 32'd16);
        check_eq("drain_empty", 32'(empty), 32'd1);
        bus.tx_busy = 1'b0;

        // Sustained concurrent push/pop with wrap-around, scoreboarded
        mcnt   = 0;
        sent   = 0;
        popped = 0;
        cyc    = 0;
        while (popped < 40 && cyc < 1000) begin
            cyc++;
            bus.in_valid = (sent < 40) && ($urandom_range(0, 3) != 0);
            bus.in_data  = 8'(sent + 64);
            bus.tx_busy  = ($urandom_range(0, 3) == 0);
            do_push = bus.in_valid && (mcnt < DEPTH);
            do_pop  = (mcnt != 0) && !bus.tx_busy;
            if (do_pop) check_eq("wrap_data", 32'(bus.tx_data), 32'(sb[0]));
            step();
            if (do_push) begin
                sb.push_back(8'(sent + 64));
                sent++;
                mcnt++;
            end
            if (do_pop) begin
                void'(sb.pop_front());
                popped++;
                mcnt--;
            end
            check_eq("wrap_count", 32'(count), 32'(mcnt));
        end
        bus.in_valid = 1'b0;
        bus.tx_busy  = 1'b0;
        check_eq("wrap_popped", 32'(popped), 32'd40);

        // Flush beats a simultaneous push and pop
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_word(8'(8'h10 + i));
        end
        check_eq("flush_pre", 32'(count), 32'd5);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        bus.tx_busy  = 1'b0;
        flush        = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.tx_busy  = 1'b1;
        check_eq("flush_count", 32'(count), 32'd0);
        check_eq("flush_empty", 32'(empty), 32'd1);
        check_eq("flush_send",  32'(bus.tx_send), 32'd0);
        push_word(8'h3C);
        check_eq("flush_next",  32'(bus.tx_data), 32'h3C);
        check_eq("flush_cnt1",  32'(count), 32'd1);
        bus.tx_busy = 1'b0;
        step();
        check_eq("flush_popped", 32'(count), 32'd0);

        // Asynchronous reset in the middle of a cycle
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push_word(8'(8'h80 + i));
        end
        check_eq("arst_pre", 32'(count), 32'd7);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_count", 32'(count), 32'd0);
        check_eq("arst_empty", 32'(empty), 32'd1);
        check_eq("arst_send",  32'(bus.tx_send), 32'd0);
        check_eq("arst_full",  32'(full), 32'd0);
        step();
        rst = 1'b0;
        step();
        check_eq("arst_ready", 32'(bus.in_ready), 32'd1);
        check_eq("arst_cnt0",  32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx_fifo
